// File: rtl/data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// data_mem_access_unit
//
// Turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses
// on a data memory with a combinational read and a clock-edge write.
// Sub-word stores use read-modify-write. Loads are lane-extracted and extended.
// Misaligned or illegal requests are answered with a fault and never touch
// memory.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high. req_ready_o is high only when idle. resp_valid_o
// is a one-cycle pulse. resp_rdata_o and resp_misaligned_o stay stable from
// that pulse until the next pulse or reset.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_write_i           1 = store, 0 = load
//   req_funct3_i          RV32I funct3 (size / sign)
//   req_addr_i            byte address
//   req_wdata_i           store data, right-aligned
//   resp_valid_o          completion pulse
//   resp_rdata_o          extended load data (0 for stores and faults)
//   resp_misaligned_o     fault flag, valid with resp_valid_o
//   mem_write_en_o        memory write enable
//   mem_write_data_o      memory write data
//   mem_address_o         memory byte address, always word-aligned
//   mem_read_data_i       memory read data (combinational on mem_address_o)
//   dbg_state_o           current FSM state, for observation only
// -----------------------------------------------------------------------------
module data_mem_access_unit #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_write_i,
    input  logic [2:0]               req_funct3_i,
    input  logic [ADDRESS_WIDTH+1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]    req_wdata_i,
    output logic                     resp_valid_o,
    output logic [DATA_WIDTH-1:0]    resp_rdata_o,
    output logic                     resp_misaligned_o,
    output logic                     mem_write_en_o,
    output logic [DATA_WIDTH-1:0]    mem_write_data_o,
    output logic [ADDRESS_WIDTH+1:0] mem_address_o,
    input  logic [DATA_WIDTH-1:0]    mem_read_data_i,
    output logic [2:0]               dbg_state_o
);

    localparam int AW = ADDRESS_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_ST_READ  = 3'd2,
        S_ST_WRITE = 3'd3,
        S_RESP     = 3'd4
    } state_e;

    state_e                  state_q;
    logic [AW-1:0]           addr_q;
    logic [2:0]              funct3_q;
    logic [15:0]             wdata_q;      // only the low halfword is merged
    logic [DATA_WIDTH-1:0]   word_q;       // word to be written
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    misaligned_q;

    // Fault check on the incoming request.
    logic req_legal;
    logic req_misalign;
    logic req_fault;

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_write_i;
            default:                req_legal = 1'b0;
        endcase
        req_misalign = 1'b0;
        case (req_funct3_i[1:0])
            2'b01:   req_misalign = req_addr_i[0];
            2'b10:   req_misalign = |req_addr_i[1:0];
            default: req_misalign = 1'b0;
        endcase
        req_fault = !req_legal || req_misalign;
    end

    // Lane extraction and extension of the word currently read.
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] load_d;

    always_comb begin
        ld_byte = mem_read_data_i[7:0];
        case (addr_q[1:0])
            2'd0: ld_byte = mem_read_data_i[7:0];
            2'd1: ld_byte = mem_read_data_i[15:8];
            2'd2: ld_byte = mem_read_data_i[23:16];
            2'd3: ld_byte = mem_read_data_i[31:24];
            default: ld_byte = mem_read_data_i[7:0];
        endcase
        ld_half = addr_q[1] ? mem_read_data_i[31:16] : mem_read_data_i[15:0];
        case (funct3_q)
            3'b000:  load_d = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_d = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_d = {24'd0, ld_byte};
            3'b101:  load_d = {16'd0, ld_half};
            default: load_d = mem_read_data_i;
        endcase
    end

    // Sub-word store: old word with the addressed lane replaced.
    logic [DATA_WIDTH-1:0] merged_d;

    always_comb begin
        merged_d = mem_read_data_i;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged_d[7:0]   = wdata_q[7:0];
                2'd1: merged_d[15:8]  = wdata_q[7:0];
                2'd2: merged_d[23:16] = wdata_q[7:0];
                2'd3: merged_d[31:24] = wdata_q[7:0];
                default: merged_d = mem_read_data_i;
            endcase
        end else if (addr_q[1]) begin
            merged_d[31:16] = wdata_q;
        end else begin
            merged_d[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            word_q       <= '0;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q   <= req_addr_i;
                        funct3_q <= req_funct3_i;
                        wdata_q  <= req_wdata_i[15:0];
                        if (req_fault) begin
                            rdata_q      <= '0;
                            misaligned_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (req_write_i) begin
                            if (req_funct3_i[1:0] == 2'b10) begin
                                word_q  <= req_wdata_i;
                                state_q <= S_ST_WRITE;
                            end else begin
                                state_q <= S_ST_READ;
                            end
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    rdata_q      <= load_d;
                    misaligned_q <= 1'b0;
                    state_q      <= S_RESP;
                end
                S_ST_READ: begin
                    word_q  <= merged_d;
                    state_q <= S_ST_WRITE;
                end
                S_ST_WRITE: begin
                    rdata_q      <= '0;
                    misaligned_q <= 1'b0;
                    state_q      <= S_RESP;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o       = (state_q == S_IDLE);
    assign resp_valid_o      = (state_q == S_RESP);
    assign resp_rdata_o      = rdata_q;
    assign resp_misaligned_o = misaligned_q;
    // Gated by reset so an access interrupted in its write cycle never lands.
    assign mem_write_en_o    = (state_q == S_ST_WRITE) && !rst_i;
    assign mem_write_data_o  = word_q;
    assign mem_address_o     = {addr_q[AW-1:2], 2'b00};
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_misaligned;
  logic          mem_write_en;
  logic [31:0]   mem_write_data;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_read_data;
  logic [2:0]    dbg_state;

  data_mem_access_unit #(.ADDRESS_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_write_i       (req_write),
    .req_funct3_i      (req_funct3),
    .req_addr_i        (req_addr),
    .req_wdata_i       (req_wdata),
    .resp_valid_o      (resp_valid),
    .resp_rdata_o      (resp_rdata),
    .resp_misaligned_o (resp_misaligned),
    .mem_write_en_o    (mem_write_en),
    .mem_write_data_o  (mem_write_data),
    .mem_address_o     (mem_address),
    .mem_read_data_i   (mem_read_data),
    .dbg_state_o       (dbg_state)
  );

  // ---------------- data memory attached to the DUT ----------------
  logic [31:0] dmem [64];
  logic [7:0]  ref_mem [256];   // byte-addressed reference image
  logic        mem_load = 1'b0;
  int          wr_count = 0;
  int          bad_align = 0;

  assign mem_read_data = dmem[mem_address[7:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++)
        dmem[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
    end else if (mem_write_en) begin
      dmem[mem_address[7:2]] <= mem_write_data;
      wr_count <= wr_count + 1;
      if (mem_address[1:0] != 2'b00) bad_align <= bad_align + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_fault(input logic w, input logic [2:0] f3, input logic [7:0] a);
    logic legal;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    if (f3[1:0] == 2'd1) return a[0];
    if (f3[1:0] == 2'd2) return (a[1:0] != 2'b00);
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [7:0] a);
    int n;
    logic [31:0] v;
    logic [7:0] idx;
    n = 1 << f3[1:0];
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      idx = a + 8'(k);
      v = v | (32'(ref_mem[idx]) << (8 * k));
    end
    if (!f3[2] && n < 4 && v[8*n-1])
      v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  function automatic void model_store(input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
    int n;
    logic [7:0] idx;
    n = 1 << f3[1:0];
    for (int k = 0; k < n; k++) begin
      idx = a + 8'(k);
      ref_mem[idx] = wd[8*k +: 8];
    end
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] wd, output logic [31:0] rd);
    int lat;
    int wr0;
    int exp_lat;
    logic flt;
    logic [31:0] exp_rd;
    flt     = model_fault(w, f3, a);
    exp_rd  = (flt || w) ? 32'd0 : model_load(f3, a);
    exp_lat = flt ? 1 : ((w && f3[1:0] != 2'd2) ? 3 : 2);
    exp_q.push_back(exp_rd);
    @(negedge clk);
    check_eq("ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    wr0 = wr_count;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check_eq($sformatf("resp_valid w%0d f%0d a%02h", w, f3, a), 32'(resp_valid), 32'd1);
    check_eq($sformatf("latency w%0d f%0d a%02h", w, f3, a), 32'(lat), 32'(exp_lat));
    check_eq($sformatf("misaligned w%0d f%0d a%02h", w, f3, a), 32'(resp_misaligned), 32'(flt));
    rd = resp_rdata;
    check_eq($sformatf("rdata w%0d f%0d a%02h", w, f3, a), resp_rdata, exp_q.pop_front());
    check_eq($sformatf("writes w%0d f%0d a%02h", w, f3, a), 32'(wr_count - wr0),
             (!flt && w) ? 32'd1 : 32'd0);
    if (!flt && w) model_store(f3, a, wd);
    @(negedge clk);
    check_eq("resp_pulse", 32'(resp_valid), 32'd0);
    check_eq("rdata_hold", resp_rdata, exp_rd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_rdata"}, resp_rdata, 32'd0);
    check_eq({tag, "_misaligned"}, 32'(resp_misaligned), 32'd0);
    check_eq({tag, "_wr_en"}, 32'(mem_write_en), 32'd0);
    check_eq({tag, "_wr_data"}, mem_write_data, 32'd0);
    check_eq({tag, "_address"}, 32'(mem_address), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic [31:0] val_a;
  logic [31:0] val_b;
  int wr0;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_funct3 = 3'd0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    mem_load = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_load = 1'b0;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Word store then load.
    do_req(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, rd);
    do_req(1'b0, 3'b010, 8'h10, 32'h0, rd);
    check_eq("plan_lw", rd, 32'hDEADBEEF);

    // Byte store and byte loads.
    do_req(1'b1, 3'b000, 8'h11, 32'h000000A5, rd);
    do_req(1'b0, 3'b010, 8'h10, 32'h0, rd);
    check_eq("plan_sb_word", rd, 32'hDEADA5EF);
    do_req(1'b0, 3'b000, 8'h11, 32'h0, rd);
    check_eq("plan_lb", rd, 32'hFFFFFFA5);
    do_req(1'b0, 3'b100, 8'h11, 32'h0, rd);
    check_eq("plan_lbu", rd, 32'h000000A5);

    // Halfword store and halfword loads.
    do_req(1'b1, 3'b001, 8'h12, 32'h00001234, rd);
    do_req(1'b0, 3'b010, 8'h10, 32'h0, rd);
    check_eq("plan_sh_word", rd, 32'h1234A5EF);
    do_req(1'b0, 3'b001, 8'h12, 32'h0, rd);
    check_eq("plan_lh_hi", rd, 32'h00001234);
    do_req(1'b0, 3'b001, 8'h10, 32'h0, rd);
    check_eq("plan_lh_lo", rd, 32'hFFFFA5EF);
    do_req(1'b0, 3'b101, 8'h10, 32'h0, rd);
    check_eq("plan_lhu", rd, 32'h0000A5EF);

    // Faults: none may touch memory.
    do_req(1'b0, 3'b010, 8'h13, 32'h0, rd);
    do_req(1'b1, 3'b001, 8'h11, 32'hFFFFFFFF, rd);
    do_req(1'b0, 3'b011, 8'h10, 32'h0, rd);
    do_req(1'b1, 3'b100, 8'h10, 32'h55555555, rd);
    do_req(1'b0, 3'b010, 8'h10, 32'h0, rd);
    check_eq("plan_fault_unchanged", rd, 32'h1234A5EF);

    // Reset during the write cycle of a word store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 8'h20;
    req_wdata = 32'h11111111;
    wr0 = wr_count;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rst_mid_wr_en_before", 32'(mem_write_en), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_mid");
    check_eq("rst_mid_no_write", 32'(wr_count - wr0), 32'd0);
    rst = 1'b0;
    do_req(1'b0, 3'b010, 8'h20, 32'h0, rd);

    // req_valid held over two back-to-back word loads.
    val_a = model_load(3'b010, 8'h18);
    val_b = model_load(3'b010, 8'h1C);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_funct3 = 3'b010;
    req_addr = 8'h18;
    for (int t = 0; t < 6; t++) begin
      check_eq($sformatf("b2b_ready t%0d", t), 32'(req_ready), (t % 3 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("b2b_resp t%0d", t), 32'(resp_valid), (t % 3 == 2) ? 32'd1 : 32'd0);
      if (t == 2 || t == 3 || t == 4) check_eq($sformatf("b2b_rdata_a t%0d", t), resp_rdata, val_a);
      if (t == 2) req_addr = 8'h1C;
      if (t == 5) begin
        check_eq("b2b_rdata_b", resp_rdata, val_b);
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("b2b_after_resp", 32'(resp_valid), 32'd0);
    check_eq("b2b_after_ready", 32'(req_ready), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      logic w;
      logic [2:0] f3;
      logic [7:0] a;
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 4) == 0) a = 8'($urandom_range(0, 255));
      else a = 8'h40 + 8'($urandom_range(0, 15));
      do_req(w, f3, a, $urandom, rd);
    end

    // Final read-back of the whole memory against the reference image.
    for (int i = 0; i < 64; i++) begin
      do_req(1'b0, 3'b010, 8'(4 * i), 32'h0, rd);
    end
    check_eq("write_alignment", 32'(bad_align), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
Load/store initiator that sits between the core's memory stage and the word-only data memory. The data memory has a combinational read and a write on the clock edge. This unit turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on that memory. Sub-word stores use a read-modify-write sequence, and loads are byte-lane extracted and extended. Misaligned or illegal accesses are flagged and never reach memory.

Parameters:
ADDRESS_WIDTH, 6, log2 of memory depth in words; byte address is ADDRESS_WIDTH+2 bits
DATA_WIDTH, 32, word width; only 32 is supported

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (size/sign)
req_addr  input  ADDRESS_WIDTH+2  byte address
req_wdata  input  DATA_WIDTH  store data, right-aligned
resp_valid  output  1  one-cycle pulse when the access completes
resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and faults
resp_misaligned  output  1  valid with resp_valid; misaligned or illegal funct3
mem_write_en  output  1  to memory write enable
mem_write_data  output  DATA_WIDTH  to memory write data
mem_address  output  ADDRESS_WIDTH+2  to memory byte address, always word-aligned (bits [1:0]=0)
mem_read_data  input  DATA_WIDTH  from memory, combinational on mem_address

Behaviour:
- Reset values:
  - State IDLE; all latched request fields 0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0.
  - mem_write_en=0, mem_write_data=0, mem_address=0.
- Request capture: a request is accepted when req_valid & req_ready at a rising edge. Addr, funct3, write and wdata are latched. req_ready=1 only in IDLE.
- States: IDLE, LOAD, ST_READ, ST_WRITE, RESP.
- Fault check at accept:
  - Legal loads: funct3 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Halfword requires addr[0]=0. Word requires addr[1:0]=00.
  - Any fault goes IDLE->RESP with resp_misaligned=1, resp_rdata=0 and no memory access.
- Load path: IDLE->LOAD->RESP.
  - In LOAD, mem_address = {addr[hi:2],2'b00}.
  - The selected lane of mem_read_data is captured at the LOAD edge.
  - Byte lane = addr[1:0]; halfword lane = addr[1]; little-endian.
  - 000/001: sign-extend. 100/101: zero-extend. 010: full word.
- SW path: IDLE->ST_WRITE->RESP.
- SB/SH path: IDLE->ST_READ->ST_WRITE->RESP.
  - In ST_READ the old word is read.
  - The low byte/halfword of wdata is merged into the addressed lane and registered.
- ST_WRITE outputs:
  - mem_write_en=1 for exactly one cycle; mem_write_data = full or merged word.
  - mem_write_en is gated by !rst, so there is no write in a reset cycle.
- mem_write_en is 0 in every other state.
- mem_address holds the latched aligned address from accept until the next accept.
- RESP:
  - resp_valid=1 for one cycle, then return to IDLE.
  - resp_rdata and resp_misaligned hold their values until the next RESP or reset.
- Latency, with accept at edge N:
  - Fault: resp_valid in cycle N+1.
  - Load and SW: resp_valid in cycle N+2.
  - SB/SH: resp_valid in cycle N+3.
- Throughput: no new request is accepted while busy. req_valid held high is accepted again in the first IDLE cycle after RESP.
- Reset mid-operation: any state goes to IDLE. The in-flight access is dropped with no response and no partial write.
- Address wrap: addresses are modulo 2^(ADDRESS_WIDTH+2); no out-of-range detection.

Test Plan:
- Reset, SW addr 0x10 data 0xDEADBEEF, then LW 0x10:
  - SW: mem_write_en high exactly one cycle; resp_valid at N+2.
  - LW: resp_rdata=0xDEADBEEF at N+2, resp_misaligned=0.
- SB addr 0x11 data 0x000000A5 over 0xDEADBEEF:
  - SB: word becomes 0xDEADA5EF; resp at N+3.
  - LB 0x11 gives 0xFFFFFFA5; LBU 0x11 gives 0x000000A5.
- SH addr 0x12 data 0x00001234:
  - SH: word becomes 0x1234A5EF.
  - LH 0x12 gives 0x00001234; LH 0x10 gives 0xFFFFA5EF; LHU 0x10 gives 0x0000A5EF.
- Faults (LW 0x13, SH 0x11, load funct3 011, store funct3 100):
  - Each gives resp_valid at N+1 with resp_misaligned=1 and resp_rdata=0.
  - mem_write_en is never asserted; the word at 0x10 is unchanged.
- rst high during the ST_WRITE cycle of SW 0x20 data 0x11111111:
  - No write occurs; LW 0x20 afterwards returns the previous value.
  - All outputs read their reset values in the cycle after the reset edge, and req_ready=1.
- req_valid held high over two back-to-back LWs:
  - Second accepted exactly in the cycle after the first RESP.
  - resp_valid pulses once per request.
  - resp_rdata holds its value between pulses.
